// File: rtl/seq_mul_25519.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_25519
// Description : Sequential 257x257 -> 514-bit unsigned shift-and-add multiplier
//               feeding the mod 2^255-19 reducer. Define SEQ_MUL_RADIX4_EN for
//               the radix-4 datapath (2 multiplier bits per cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_25519 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [256:0] a,
    input  logic [256:0] b,
    output logic [513:0] product,
    output logic         done
);

`ifdef SEQ_MUL_RADIX4_EN
    localparam int         C_MPW   = 258;
    localparam int         C_SHIFT = 2;
    localparam logic [8:0] C_ITERS = 9'd129;
`else
    localparam int         C_MPW   = 257;
    localparam int         C_SHIFT = 1;
    localparam logic [8:0] C_ITERS = 9'd257;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [513:0]       r_mcand;
    logic [C_MPW-1:0]   r_mplier;
    logic [513:0]       r_acc;
    logic [8:0]         r_cnt;
    logic [513:0]       r_product;
    logic [513:0]       w_addend;
    logic [513:0]       w_a_ext;

    assign w_a_ext = {257'd0, a};

`ifdef SEQ_MUL_RADIX4_EN
    // 3x multiplicand is kept in its own register and shifted in lockstep
    logic [513:0] r_mcand3;

    always_comb begin
        w_addend = '0;
        case (r_mplier[1:0])
            2'd1:    w_addend = r_mcand;
            2'd2:    w_addend = r_mcand << 1;
            2'd3:    w_addend = r_mcand3;
            default: w_addend = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand3 <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_mcand3 <= w_a_ext + (w_a_ext << 1);
        end else if (r_state == S_RUN) begin
            r_mcand3 <= r_mcand3 << C_SHIFT;
        end
    end
`else
    always_comb begin
        w_addend = '0;
        if (r_mplier[0]) begin
            w_addend = r_mcand;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_RUN;
            S_RUN:    if (r_cnt == 9'd1) w_next_state = S_COMMIT;
            S_COMMIT: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_a_ext;
                        r_mplier <= C_MPW'(b);
                        r_acc    <= '0;
                        r_cnt    <= C_ITERS;
                    end
                end
                S_RUN: begin
                    r_acc    <= r_acc + w_addend;
                    r_mcand  <= r_mcand << C_SHIFT;
                    r_mplier <= r_mplier >> C_SHIFT;
                    r_cnt    <= r_cnt - 9'd1;
                end
                S_COMMIT: begin
                    r_product <= r_acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;
    assign done    = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: doc/seq_mul_25519.md
SEQ_MUL_25519 -- requirements
Module: seq_mul_25519

Interface
REQ-001 SHALL have parameter none; operand width is fixed at 257 bits and product width at 514 bits, matching the 514-bit input of the downstream mod-2^255-19 reducer.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  257  unsigned multiplicand, captured on accepted start.
REQ-006 SHALL have port b  input  257  unsigned multiplier, captured on accepted start.
REQ-007 SHALL have port product  output  514  registered unsigned a*b, drives reducer x directly.
REQ-008 SHALL have port done  output  1  level; high in IDLE (product valid), low while computing.

Function
REQ-009 SHALL implement states IDLE, RUN and COMMIT only; no other encodings reachable.
REQ-010 SHALL, in IDLE with start=1 at edge E0, latch a into a 514-bit multiplicand register (zero-extended), b into a multiplier shift register, clear the 514-bit accumulator, load the iteration counter, and enter RUN.
REQ-011 SHALL, in IDLE with start=0, hold all registers and product unchanged.
REQ-012 SHALL, each RUN edge (radix-2), add the multiplicand to the accumulator when multiplier bit 0 is 1, shift multiplicand left by 1, shift multiplier right by 1, decrement counter.
REQ-013 SHALL perform exactly 257 RUN iterations (edges E1..E257) regardless of operand values; no early termination.
REQ-014 SHALL, at edge E258 (COMMIT), write the accumulator to product and return to IDLE; done rises after E258; total latency 258 cycles from accepted start.
REQ-015 SHALL keep product stable and equal to the previous result throughout RUN and COMMIT until E258 overwrites it.
REQ-016 SHALL ignore start while in RUN or COMMIT; captured operands unaffected by a/b changes after E0.
REQ-017 SHALL, with start held high continuously, accept a new operation on the first IDLE edge after COMMIT (one IDLE cycle between jobs, done high for exactly one cycle).
REQ-018 SHALL perform all arithmetic modulo 2^514 with no truncation; max product (2^257-1)^2 fits without overflow.

Reset
REQ-019 SHALL, on rst_n low, immediately force state=IDLE, product=0, done=1, accumulator/multiplicand/multiplier/counter=0, independent of clk.
REQ-020 SHALL, on reset asserted mid-RUN, abandon the operation; no partial result ever appears on product.
REQ-021 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-022 SHALL support macro SEQ_MUL_RADIX4_EN.
REQ-023 SHALL, with SEQ_MUL_RADIX4_EN defined, consume 2 multiplier bits per RUN edge (add 0, 1x, 2x or 3x multiplicand; 3x from a precomputed register loaded at E0), multiplier zero-extended to 258 bits, 129 RUN edges, COMMIT at E130, latency 130 cycles.
REQ-024 SHALL, without the macro, use radix-2 per REQ-012..014 (latency 258); results bit-identical in both builds.

Verification
REQ-025 SHALL cover: reset, then a=0, b=2^256+5, start 1 cycle -> done low E1..E258, product=0, done=1 after E258 (E130 radix-4).
REQ-026 SHALL cover: a=1, b=2^255-19 -> product=2^255-19; a=2^255-19, b=2 -> product=2^256-38.
REQ-027 SHALL cover: a=b=2^257-1 -> product=2^514-2^258+1, no overflow.
REQ-028 SHALL cover: start pulsed at E0 with a=3,b=5, then a=7,b=9 and start=1 at E10 -> product=15, second request ignored.
REQ-029 SHALL cover: rst_n low at E100 of a=b=2^200 job -> product=0, done=1 immediately; next job a=6,b=7 -> product=42.
REQ-030 SHALL cover: start held high, operand pairs (2,3),(4,5) -> product 6 then 20, done high one cycle between jobs; repeat in both macro builds.
